// File: rtl/mips_cpu_divider_param.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU; quotient feeds LO, remainder feeds HI.
// Fixed latency: WIDTH+2 edges after acceptance, or 1 edge on divide-by-zero.
module mips_cpu_divider_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic             ovf
);

   localparam int unsigned W     = WIDTH;
   localparam int unsigned W1    = WIDTH + 1;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   logic [1:0]       state;
   logic [1:0]       state_n;
   logic [W1-1:0]    acc;
   logic [W1-1:0]    shifted;
   logic [W-1:0]     q;
   logic [W-1:0]     dvs;
   logic [W-1:0]     dvd_mag;
   logic [W-1:0]     dvs_mag;
   logic [CNT_W-1:0] cnt;
   logic             sign_q;
   logic             sign_r;
   logic             ovf_p;
   logic             dbz_p;
   logic             accept;
   logic             last;
   logic             div_zero;

   // Operand magnitudes; the most-negative value maps to 2^(W-1) as unsigned.
   always_comb begin
      dvd_mag  = (is_signed && Dividend[W-1]) ? W'(-Dividend) : Dividend;
      dvs_mag  = (is_signed && Divisor[W-1])  ? W'(-Divisor)  : Divisor;
      div_zero = (Divisor == '0);
      accept   = start && !busy;
      last     = (cnt == CNT_W'(W - 1));
      shifted  = W1'({acc, q[W-1]});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_DONE: if (accept) state_n = div_zero ? S_DONE : S_CALC;
         S_CALC:         if (last) state_n = S_FIX;
         S_FIX:          state_n = S_DONE;
         default:        state_n = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; results are published only on the DONE edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Quotient  <= '0;
         Remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
         acc       <= '0;
         q         <= '0;
         dvs       <= '0;
         cnt       <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         ovf_p     <= 1'b0;
         dbz_p     <= 1'b0;
      end else begin
         busy <= (state_n == S_CALC) || (state_n == S_FIX);
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  done   <= 1'b0;
                  dbz    <= 1'b0;
                  ovf    <= 1'b0;
                  sign_q <= is_signed & (Dividend[W-1] ^ Divisor[W-1]);
                  sign_r <= is_signed & Dividend[W-1];
                  ovf_p  <= is_signed && (Dividend == MOST_NEG) && (Divisor == '1);
                  dbz_p  <= div_zero;
                  acc    <= '0;
                  q      <= div_zero ? '0 : dvd_mag;
                  dvs    <= dvs_mag;
                  cnt    <= '0;
               end else if (state == S_DONE && !done) begin
                  done      <= 1'b1;
                  dbz       <= dbz_p;
                  ovf       <= ovf_p;
                  Quotient  <= q;
                  Remainder <= acc[W-1:0];
               end
            end
            S_CALC: begin
               if (shifted >= W1'(dvs)) begin
                  acc <= shifted - W1'(dvs);
                  q   <= {q[W-2:0], 1'b1};
               end else begin
                  acc <= shifted;
                  q   <= {q[W-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
            end
            S_FIX: begin
               q   <= sign_q ? W'(-q) : q;
               acc <= sign_r ? W1'(-acc) : acc;
            end
            default: ;
         endcase
      end
   end

endmodule
